// File: rtl/sram_dual_sync_be_clr_if.sv
// Port bundle for the dual-port RAM: two access ports and the clear-engine controls.
interface sram_dual_sync_be_clr_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LANE_WIDTH = 8
);
  localparam int unsigned NLANES = DATA_WIDTH / LANE_WIDTH;

  logic [ADDR_WIDTH-1:0] ADDR0;
  logic [DATA_WIDTH-1:0] DATA0;
  logic                  cen0;
  logic [NLANES-1:0]     we0;
  logic [DATA_WIDTH-1:0] Q0;

  logic [ADDR_WIDTH-1:0] ADDR1;
  logic [DATA_WIDTH-1:0] DATA1;
  logic                  cen1;
  logic [NLANES-1:0]     we1;
  logic [DATA_WIDTH-1:0] Q1;

  logic                  clr_req;
  logic                  busy;
  logic                  clr_done;

  modport master (
    output ADDR0, DATA0, cen0, we0,
    output ADDR1, DATA1, cen1, we1,
    output clr_req,
    input  Q0, Q1, busy, clr_done
  );

  modport slave (
    input  ADDR0, DATA0, cen0, we0,
    input  ADDR1, DATA1, cen1, we1,
    input  clr_req,
    output Q0, Q1, busy, clr_done
  );
endinterface

// File: rtl/sram_dual_sync_be_clr.sv
// Single-clock true dual-port RAM with byte-lane writes, selectable read-during-write
// behaviour, port-0 write priority on collisions and a fill-with-constant clear engine.
module sram_dual_sync_be_clr #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned LANE_WIDTH   = 8,
  parameter int unsigned RDW_MODE     = 0,
  parameter int unsigned CLR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE = '0
) (
  input logic clk,
  input logic reset_n,
  sram_dual_sync_be_clr_if.slave bus
);

  localparam int unsigned NLANES = DATA_WIDTH / LANE_WIDTH;
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLR_ON_RESET != 0) ? CLEAR : IDLE;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] q0_q, q1_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  idle;
  logic                  same_addr;
  logic [NLANES-1:0]     wen0, wen1;
  logic [DATA_WIDTH-1:0] rd0, rd1;
  logic [DATA_WIDTH-1:0] merged0, merged1;

  // Clear-engine state, counter and registered status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
      busy_q  <= (CLR_ON_RESET != 0);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state: IDLE accepts clr_req, CLEAR walks every address once then returns
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = ADDR_WIDTH'(cnt_q + 1'b1);
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
  end

  // Effective lane enables and the post-write word seen at each port's address
  always_comb begin
    idle      = (state_q == IDLE);
    same_addr = (bus.ADDR0 == bus.ADDR1);
    rd0       = mem[bus.ADDR0];
    rd1       = mem[bus.ADDR1];
    wen0      = (idle && bus.cen0) ? bus.we0 : '0;
    wen1      = (idle && bus.cen1) ? bus.we1 : '0;
    // Port 0 owns any lane both ports write at the same address
    if (same_addr) begin
      wen1 = wen1 & ~wen0;
    end
    merged0 = rd0;
    merged1 = rd1;
    for (int unsigned i = 0; i < NLANES; i++) begin
      if (same_addr && wen1[i]) merged0[i*LANE_WIDTH +: LANE_WIDTH] = bus.DATA1[i*LANE_WIDTH +: LANE_WIDTH];
      if (wen0[i])              merged0[i*LANE_WIDTH +: LANE_WIDTH] = bus.DATA0[i*LANE_WIDTH +: LANE_WIDTH];
      if (same_addr && wen0[i]) merged1[i*LANE_WIDTH +: LANE_WIDTH] = bus.DATA0[i*LANE_WIDTH +: LANE_WIDTH];
      if (wen1[i])              merged1[i*LANE_WIDTH +: LANE_WIDTH] = bus.DATA1[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  // Array update: clear engine has exclusive ownership, otherwise per-lane port writes
  always_ff @(posedge clk) begin
    if (!idle) begin
      mem[cnt_q] <= CLR_VALUE;
    end else begin
      for (int unsigned i = 0; i < NLANES; i++) begin
        if (wen0[i]) mem[bus.ADDR0][i*LANE_WIDTH +: LANE_WIDTH] <= bus.DATA0[i*LANE_WIDTH +: LANE_WIDTH];
        if (wen1[i]) mem[bus.ADDR1][i*LANE_WIDTH +: LANE_WIDTH] <= bus.DATA1[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // Registered read data; holds while the port is disabled or the clear is running
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q0_q <= '0;
      q1_q <= '0;
    end else if (idle) begin
      if (bus.cen0) q0_q <= (RDW_MODE != 0) ? merged0 : rd0;
      if (bus.cen1) q1_q <= (RDW_MODE != 0) ? merged1 : rd1;
    end
  end

  assign bus.Q0       = q0_q;
  assign bus.Q1       = q1_q;
  assign bus.busy     = busy_q;
  assign bus.clr_done = done_q;

endmodule

// File: tb/tb_sram_dual_sync_be_clr.sv
// Directed bench: one read-first and one write-first instance driven with identical stimulus.
module tb_sram_dual_sync_be_clr;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned LW = 8;
  localparam logic [15:0] CLRV = 16'hA5A5;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  sram_dual_sync_be_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(LW)) b0 ();
  sram_dual_sync_be_clr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(LW)) b1 ();

  assign b1.ADDR0   = b0.ADDR0;
  assign b1.DATA0   = b0.DATA0;
  assign b1.cen0    = b0.cen0;
  assign b1.we0     = b0.we0;
  assign b1.ADDR1   = b0.ADDR1;
  assign b1.DATA1   = b0.DATA1;
  assign b1.cen1    = b0.cen1;
  assign b1.we1     = b0.we1;
  assign b1.clr_req = b0.clr_req;

  sram_dual_sync_be_clr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(LW),
    .RDW_MODE(0), .CLR_ON_RESET(1), .CLR_VALUE(CLRV)
  ) u0 (
    .clk(clk), .reset_n(reset_n), .bus(b0)
  );

  sram_dual_sync_be_clr #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(LW),
    .RDW_MODE(1), .CLR_ON_RESET(1), .CLR_VALUE(CLRV)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    b0.cen0    = 1'b0;
    b0.we0     = 2'b00;
    b0.ADDR0   = '0;
    b0.DATA0   = '0;
    b0.cen1    = 1'b0;
    b0.we1     = 2'b00;
    b0.ADDR1   = '0;
    b0.DATA1   = '0;
    b0.clr_req = 1'b0;
  endtask

  // Watches a running clear for a bounded window, counting busy samples and done pulses
  task automatic watch_clear(output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (b0.busy === 1'b1) busy_n++;
      if (b0.clr_done === 1'b1) done_n++;
      step();
    end
  endtask

  task automatic test_reset();
    int busy_n;
    int done_n;
    reset_n = 1'b0;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (b0.Q0 !== 16'h0000) begin errors++; $display("FAIL reset_q0 got=%h exp=%h", b0.Q0, 16'h0000); end
    checks++; if (b0.Q1 !== 16'h0000) begin errors++; $display("FAIL reset_q1 got=%h exp=%h", b0.Q1, 16'h0000); end
    checks++; if (b0.busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", b0.busy); end
    checks++; if (b0.clr_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", b0.clr_done); end
    reset_n = 1'b1;
    watch_clear(busy_n, done_n);
    checks++; if (busy_n != 16) begin errors++; $display("FAIL reset_clear_len got=%0d exp=16", busy_n); end
    checks++; if (done_n != 1) begin errors++; $display("FAIL reset_clear_done got=%0d exp=1", done_n); end
    for (int a = 0; a < 16; a++) begin
      b0.ADDR0 = AW'(a);
      b0.cen0  = 1'b1;
      b0.ADDR1 = AW'(15 - a);
      b0.cen1  = 1'b1;
      step();
      checks++; if (b0.Q0 !== CLRV) begin errors++; $display("FAIL clr_read_p0 addr=%0d got=%h exp=%h", a, b0.Q0, CLRV); end
      checks++; if (b1.Q1 !== CLRV) begin errors++; $display("FAIL clr_read_p1 addr=%0d got=%h exp=%h", 15 - a, b1.Q1, CLRV); end
    end
    set_idle();
  endtask

  task automatic test_lane_write();
    b0.ADDR0 = 4'd3; b0.DATA0 = 16'h1234; b0.we0 = 2'b11; b0.cen0 = 1'b1;
    step();
    b0.DATA0 = 16'hFF00; b0.we0 = 2'b01;
    step();
    set_idle();
    b0.ADDR1 = 4'd3; b0.cen1 = 1'b1;
    step();
    checks++; if (b0.Q1 !== 16'h1200) begin errors++; $display("FAIL lane_write_m0 got=%h exp=%h", b0.Q1, 16'h1200); end
    checks++; if (b1.Q1 !== 16'h1200) begin errors++; $display("FAIL lane_write_m1 got=%h exp=%h", b1.Q1, 16'h1200); end
    set_idle();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    for (int k = 0; k < 5; k++) begin
      b0.cen0  = (k < 4);
      b0.we0   = 2'b11;
      b0.ADDR0 = AW'(10 + k);
      b0.DATA0 = 16'h0A00 + 16'(k);
      b0.cen1  = (k > 0);
      b0.we1   = 2'b00;
      b0.ADDR1 = AW'(10 + k - 1);
      step();
      if (k > 0) begin
        exp = 16'h0A00 + 16'(k - 1);
        checks++; if (b0.Q1 !== exp) begin errors++; $display("FAIL b2b_m0 k=%0d got=%h exp=%h", k, b0.Q1, exp); end
        checks++; if (b1.Q1 !== exp) begin errors++; $display("FAIL b2b_m1 k=%0d got=%h exp=%h", k, b1.Q1, exp); end
      end
    end
    set_idle();
  endtask

  task automatic test_rdw();
    b0.ADDR0 = 4'd5; b0.DATA0 = 16'h0000; b0.we0 = 2'b11; b0.cen0 = 1'b1;
    step();
    b0.DATA0 = 16'hBEEF;
    b0.ADDR1 = 4'd5; b0.cen1 = 1'b1; b0.we1 = 2'b00;
    step();
    checks++; if (b0.Q1 !== 16'h0000) begin errors++; $display("FAIL rdw_cross_m0 got=%h exp=%h", b0.Q1, 16'h0000); end
    checks++; if (b1.Q1 !== 16'hBEEF) begin errors++; $display("FAIL rdw_cross_m1 got=%h exp=%h", b1.Q1, 16'hBEEF); end
    checks++; if (b0.Q0 !== 16'h0000) begin errors++; $display("FAIL rdw_same_m0 got=%h exp=%h", b0.Q0, 16'h0000); end
    checks++; if (b1.Q0 !== 16'hBEEF) begin errors++; $display("FAIL rdw_same_m1 got=%h exp=%h", b1.Q0, 16'hBEEF); end
    set_idle();
    b0.ADDR1 = 4'd5; b0.cen1 = 1'b1;
    step();
    checks++; if (b0.Q1 !== 16'hBEEF) begin errors++; $display("FAIL rdw_after_m0 got=%h exp=%h", b0.Q1, 16'hBEEF); end
    set_idle();
  endtask

  task automatic test_collision();
    b0.ADDR0 = 4'd7; b0.DATA0 = 16'h1111; b0.we0 = 2'b10; b0.cen0 = 1'b1;
    b0.ADDR1 = 4'd7; b0.DATA1 = 16'h2222; b0.we1 = 2'b11; b0.cen1 = 1'b1;
    step();
    checks++; if (b0.Q0 !== CLRV) begin errors++; $display("FAIL coll_rdw_m0 got=%h exp=%h", b0.Q0, CLRV); end
    checks++; if (b1.Q0 !== 16'h1122) begin errors++; $display("FAIL coll_rdw_m1_p0 got=%h exp=%h", b1.Q0, 16'h1122); end
    checks++; if (b1.Q1 !== 16'h1122) begin errors++; $display("FAIL coll_rdw_m1_p1 got=%h exp=%h", b1.Q1, 16'h1122); end
    set_idle();
    b0.ADDR0 = 4'd7; b0.cen0 = 1'b1;
    step();
    checks++; if (b0.Q0 !== 16'h1122) begin errors++; $display("FAIL coll_read_m0 got=%h exp=%h", b0.Q0, 16'h1122); end
    checks++; if (b1.Q0 !== 16'h1122) begin errors++; $display("FAIL coll_read_m1 got=%h exp=%h", b1.Q0, 16'h1122); end
    set_idle();
  endtask

  task automatic test_clear_req();
    int busy_n;
    int done_n;
    b0.ADDR0 = 4'd3; b0.cen0 = 1'b1;
    step();
    checks++; if (b0.Q0 !== 16'h1200) begin errors++; $display("FAIL clrreq_pre_q0 got=%h exp=%h", b0.Q0, 16'h1200); end
    set_idle();
    b0.clr_req = 1'b1;
    step();
    b0.clr_req = 1'b0;
    busy_n = 0;
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (b0.busy === 1'b1) busy_n++;
      if (b0.clr_done === 1'b1) done_n++;
      b0.clr_req = (k == 0);
      b0.cen0    = (k < 6);
      b0.we0     = 2'b11;
      b0.ADDR0   = 4'd2;
      b0.DATA0   = 16'h5555;
      step();
    end
    set_idle();
    checks++; if (busy_n != 16) begin errors++; $display("FAIL clrreq_len got=%0d exp=16", busy_n); end
    checks++; if (done_n != 1) begin errors++; $display("FAIL clrreq_done got=%0d exp=1", done_n); end
    checks++; if (b0.Q0 !== 16'h1200) begin errors++; $display("FAIL clrreq_q0_hold got=%h exp=%h", b0.Q0, 16'h1200); end
    b0.ADDR0 = 4'd2; b0.cen0 = 1'b1;
    b0.ADDR1 = 4'd3; b0.cen1 = 1'b1;
    step();
    checks++; if (b0.Q0 !== CLRV) begin errors++; $display("FAIL clrreq_addr2 got=%h exp=%h", b0.Q0, CLRV); end
    checks++; if (b0.Q1 !== CLRV) begin errors++; $display("FAIL clrreq_addr3 got=%h exp=%h", b0.Q1, CLRV); end
    set_idle();
  endtask

  task automatic test_reset_mid_clear();
    int busy_n;
    int done_n;
    b0.ADDR0 = 4'd12; b0.DATA0 = 16'h3C3C; b0.we0 = 2'b11; b0.cen0 = 1'b1;
    step();
    set_idle();
    b0.ADDR0 = 4'd12; b0.cen0 = 1'b1;
    b0.ADDR1 = 4'd12; b0.cen1 = 1'b1;
    step();
    checks++; if (b0.Q0 !== 16'h3C3C) begin errors++; $display("FAIL mid_pre_q0 got=%h exp=%h", b0.Q0, 16'h3C3C); end
    set_idle();
    b0.clr_req = 1'b1;
    step();
    b0.clr_req = 1'b0;
    repeat (6) step();
    checks++; if (b0.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got=%b exp=1", b0.busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (b0.Q0 !== 16'h0000) begin errors++; $display("FAIL mid_rst_q0 got=%h exp=%h", b0.Q0, 16'h0000); end
    checks++; if (b0.Q1 !== 16'h0000) begin errors++; $display("FAIL mid_rst_q1 got=%h exp=%h", b0.Q1, 16'h0000); end
    checks++; if (b0.busy !== 1'b1) begin errors++; $display("FAIL mid_rst_busy got=%b exp=1", b0.busy); end
    step();
    reset_n = 1'b1;
    watch_clear(busy_n, done_n);
    checks++; if (busy_n != 16) begin errors++; $display("FAIL mid_clear_len got=%0d exp=16", busy_n); end
    checks++; if (done_n != 1) begin errors++; $display("FAIL mid_clear_done got=%0d exp=1", done_n); end
    checks++; if (b0.Q0 !== 16'h0000) begin errors++; $display("FAIL mid_post_q0 got=%h exp=%h", b0.Q0, 16'h0000); end
    checks++; if (b0.Q1 !== 16'h0000) begin errors++; $display("FAIL mid_post_q1 got=%h exp=%h", b0.Q1, 16'h0000); end
    b0.ADDR0 = 4'd12; b0.cen0 = 1'b1;
    step();
    checks++; if (b0.Q0 !== CLRV) begin errors++; $display("FAIL mid_addr12 got=%h exp=%h", b0.Q0, CLRV); end
    set_idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lane_write();
    test_back_to_back();
    test_rdw();
    test_collision();
    test_clear_req();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
